// File: rtl/reg_file_2w2r.sv
// reg_file_2w2r: parametrised two-write / two-read register file.
// Features: optional hardwired zero entry, port-1-wins write collision,
// same-cycle write-to-read bypass, pending-write scoreboard and a
// sequenced bulk-clear engine with a Busy / Clr_Done handshake.
module reg_file_2w2r #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] R_Addr_A,
    input  logic [AW-1:0] R_Addr_B,
    output logic [DW-1:0] R_Data_A,
    output logic [DW-1:0] R_Data_B,
    input  logic          W_En0,
    input  logic          W_En1,
    input  logic [AW-1:0] W_Addr0,
    input  logic [AW-1:0] W_Addr1,
    input  logic [DW-1:0] W_Data0,
    input  logic [DW-1:0] W_Data1,
    input  logic          Set_Pend,
    input  logic [AW-1:0] P_Addr,
    output logic          Pend_A,
    output logic          Pend_B,
    input  logic          Clr_Req,
    output logic          Busy,
    output logic          Clr_Done
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [AW-1:0]    CNT_MAX = {AW{1'b1}};
    localparam logic [AW-1:0]    CNT_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    ADDR_Z  = {AW{1'b0}};
    localparam logic [DEPTH-1:0] HOT_ONE = {{(DEPTH-1){1'b0}}, 1'b1};
    // Entry 0 is excluded from writes and pending marks when it is hardwired.
    localparam logic [DEPTH-1:0] WR_MASK = ZERO_REG ? ~HOT_ONE : {DEPTH{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];

    logic             idle_s;
    logic [DEPTH-1:0] we0_hot_s;
    logic [DEPTH-1:0] we1_hot_s;
    logic [DEPTH-1:0] set_hot_s;
    logic [DEPTH-1:0] clr_hot_s;

    // Read mux: hardwired zero, then port-1 bypass, then port-0 bypass, then array.
    function automatic logic [DW-1:0] read_port(
        input logic [AW-1:0] addr,
        input logic [DW-1:0] stored,
        input logic          byp_en,
        input logic          en0,
        input logic [AW-1:0] a0,
        input logic [DW-1:0] d0,
        input logic          en1,
        input logic [AW-1:0] a1,
        input logic [DW-1:0] d1
    );
        logic [DW-1:0] r;
        if (ZERO_REG && (addr == ADDR_Z)) begin
            r = {DW{1'b0}};
        end else if (byp_en && en1 && (a1 == addr)) begin
            r = d1;
        end else if (byp_en && en0 && (a0 == addr)) begin
            r = d0;
        end else begin
            r = stored;
        end
        return r;
    endfunction

    // Decode the per-entry one-hot write / set / clear strobes for this cycle.
    always_comb begin
        idle_s = (state_q == ST_IDLE);
        if (idle_s && W_En0) begin
            we0_hot_s = (HOT_ONE << W_Addr0) & WR_MASK;
        end else begin
            we0_hot_s = {DEPTH{1'b0}};
        end
        if (idle_s && W_En1) begin
            we1_hot_s = (HOT_ONE << W_Addr1) & WR_MASK;
        end else begin
            we1_hot_s = {DEPTH{1'b0}};
        end
        if (idle_s && Set_Pend) begin
            set_hot_s = (HOT_ONE << P_Addr) & WR_MASK;
        end else begin
            set_hot_s = {DEPTH{1'b0}};
        end
        if (state_q == ST_CLEAR) begin
            clr_hot_s = HOT_ONE << cnt_q;
        end else begin
            clr_hot_s = {DEPTH{1'b0}};
        end
    end

    // Next array contents: clear engine, then port 1, then port 0 (port 1 wins).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_hot_s[i]) begin
                mem_d[i] = {DW{1'b0}};
            end else if (we1_hot_s[i]) begin
                mem_d[i] = W_Data1;
            end else if (we0_hot_s[i]) begin
                mem_d[i] = W_Data0;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Next scoreboard: a new producer (set) supersedes a completing write (clear).
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_hot_s[i]) begin
                pend_d[i] = 1'b0;
            end else if (set_hot_s[i]) begin
                pend_d[i] = 1'b1;
            end else if (we0_hot_s[i] || we1_hot_s[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Bulk-clear sequencer; Busy / Clr_Done are registered decodes of the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Clr_Req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = ADDR_Z;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = ADDR_Z;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
        done_d = (state_d == ST_DONE);
    end

    // State registers with asynchronous reset of every entry and pending bit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= ADDR_Z;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            mem_q   <= mem_d;
        end
    end

    // Combinational read ports and pending lookups; bypass only while idle.
    always_comb begin
        R_Data_A = read_port(R_Addr_A, mem_q[R_Addr_A], idle_s,
                             W_En0, W_Addr0, W_Data0, W_En1, W_Addr1, W_Data1);
        R_Data_B = read_port(R_Addr_B, mem_q[R_Addr_B], idle_s,
                             W_En0, W_Addr0, W_Data0, W_En1, W_Addr1, W_Data1);
        if (ZERO_REG && (R_Addr_A == ADDR_Z)) begin
            Pend_A = 1'b0;
        end else begin
            Pend_A = pend_q[R_Addr_A];
        end
        if (ZERO_REG && (R_Addr_B == ADDR_Z)) begin
            Pend_B = 1'b0;
        end else begin
            Pend_B = pend_q[R_Addr_B];
        end
    end

    assign Busy     = busy_q;
    assign Clr_Done = done_q;

endmodule

// File: tb/tb_reg_file_2w2r.sv
// Bench for reg_file_2w2r: randomized traffic against an array-based
// reference model, plus directed scenarios with hand-computed expectations.
module tb_reg_file_2w2r;

    localparam int DEPTH = 32;

    logic        CLK;
    logic        RST;
    logic [4:0]  R_Addr_A, R_Addr_B;
    logic [31:0] R_Data_A, R_Data_B;
    logic        W_En0, W_En1;
    logic [4:0]  W_Addr0, W_Addr1;
    logic [31:0] W_Data0, W_Data1;
    logic        Set_Pend;
    logic [4:0]  P_Addr;
    logic        Pend_A, Pend_B;
    logic        Clr_Req;
    logic        Busy;
    logic        Clr_Done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: plain storage plus a clear-progress index
    // (-1 idle, 0..DEPTH-1 clearing, DEPTH = done cycle).
    logic [31:0] mem_m [DEPTH];
    bit          pend_m [DEPTH];
    int          clear_pos = -1;

    reg_file_2w2r #(.DW(32), .AW(5), .ZERO_REG(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
        .R_Data_A(R_Data_A), .R_Data_B(R_Data_B),
        .W_En0(W_En0), .W_En1(W_En1),
        .W_Addr0(W_Addr0), .W_Addr1(W_Addr1),
        .W_Data0(W_Data0), .W_Data1(W_Data1),
        .Set_Pend(Set_Pend), .P_Addr(P_Addr),
        .Pend_A(Pend_A), .Pend_B(Pend_B),
        .Clr_Req(Clr_Req), .Busy(Busy), .Clr_Done(Clr_Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic cmp1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]  = 32'd0;
            pend_m[i] = 1'b0;
        end
        clear_pos = -1;
    endtask

    task automatic model_step();
        if (clear_pos < 0) begin
            if (W_En0 && W_Addr0 != 5'd0) mem_m[W_Addr0] = W_Data0;
            if (W_En1 && W_Addr1 != 5'd0) mem_m[W_Addr1] = W_Data1;
            if (W_En0) pend_m[W_Addr0] = 1'b0;
            if (W_En1) pend_m[W_Addr1] = 1'b0;
            if (Set_Pend && P_Addr != 5'd0) pend_m[P_Addr] = 1'b1;
            if (Clr_Req) clear_pos = 0;
        end else if (clear_pos < DEPTH) begin
            mem_m[clear_pos]  = 32'd0;
            pend_m[clear_pos] = 1'b0;
            clear_pos++;
        end else begin
            clear_pos = -1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (clear_pos < 0) begin
            if (W_En1 && W_Addr1 == a) return W_Data1;
            if (W_En0 && W_Addr0 == a) return W_Data0;
        end
        return mem_m[a];
    endfunction

    function automatic logic exp_pend(input logic [4:0] a);
        return (a != 5'd0) && pend_m[a];
    endfunction

    // Model update on every clock edge and on asynchronous reset.
    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) model_reset();
            else model_step();
        end
    end

    // Compare process: 1 time unit before each rising edge.
    initial begin
        forever begin
            @(negedge CLK);
            #4;
            if (chk_en) begin
                cmp("rd_a", R_Data_A, exp_rd(R_Addr_A));
                cmp("rd_b", R_Data_B, exp_rd(R_Addr_B));
                cmp1("pend_a", Pend_A, exp_pend(R_Addr_A));
                cmp1("pend_b", Pend_B, exp_pend(R_Addr_B));
                cmp1("busy", Busy, (clear_pos >= 0) && (clear_pos < DEPTH));
                cmp1("done", Clr_Done, clear_pos == DEPTH);
            end
        end
    end

    task automatic idle_inputs();
        W_En0 = 1'b0; W_En1 = 1'b0; W_Addr0 = 5'd0; W_Addr1 = 5'd0;
        W_Data0 = 32'd0; W_Data1 = 32'd0; Set_Pend = 1'b0; P_Addr = 5'd0;
        Clr_Req = 1'b0; R_Addr_A = 5'd0; R_Addr_B = 5'd0;
    endtask

    task automatic rand_inputs();
        W_En0   = 1'($urandom_range(0, 1));
        W_En1   = 1'($urandom_range(0, 1));
        W_Addr0 = 5'($urandom_range(0, 31));
        W_Addr1 = ($urandom_range(0, 3) == 0) ? W_Addr0 : 5'($urandom_range(0, 31));
        W_Data0 = $urandom;
        W_Data1 = $urandom;
        Set_Pend = 1'($urandom_range(0, 1));
        P_Addr  = ($urandom_range(0, 2) == 0) ? W_Addr0 : 5'($urandom_range(0, 31));
        R_Addr_A = ($urandom_range(0, 2) == 0) ? W_Addr1 : 5'($urandom_range(0, 31));
        R_Addr_B = ($urandom_range(0, 2) == 0) ? W_Addr0 : 5'($urandom_range(0, 31));
        Clr_Req = ($urandom_range(0, 49) == 0);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic peek();
        #4;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_at;

        RST = 1'b1;
        idle_inputs();
        model_reset();
        step();
        step();
        chk_en = 1'b1;
        R_Addr_A = 5'd5;
        R_Addr_B = 5'd31;
        peek();
        cmp1("rst_busy", Busy, 1'b0);
        cmp1("rst_done", Clr_Done, 1'b0);
        cmp("rst_rd", R_Data_B, 32'd0);
        step();
        RST = 1'b0;

        // Random traffic, including occasional clears.
        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            step();
        end

        // Reset in the middle of running traffic.
        RST = 1'b1;
        idle_inputs();
        peek();
        cmp1("mid_rst_busy", Busy, 1'b0);
        step();
        RST = 1'b0;
        W_En0 = 1'b1; W_Addr0 = 5'd0;  W_Data0 = 32'hDEADBEEF;
        W_En1 = 1'b1; W_Addr1 = 5'd31; W_Data1 = 32'h12345678;
        step();
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            R_Addr_A = 5'(i);
            peek();
            cmp("zero_reg_rd", R_Data_A, (i == 31) ? 32'h12345678 : 32'd0);
            step();
        end

        // Dual-write collision on the same address: port 1 wins.
        W_En0 = 1'b1; W_Addr0 = 5'd7; W_Data0 = 32'hAAAA0000;
        W_En1 = 1'b1; W_Addr1 = 5'd7; W_Data1 = 32'h0000BBBB;
        R_Addr_A = 5'd7;
        peek();
        cmp("col_bypass", R_Data_A, 32'h0000BBBB);
        step();
        idle_inputs();
        R_Addr_A = 5'd7;
        peek();
        cmp("col_stored", R_Data_A, 32'h0000BBBB);
        step();
        W_En0 = 1'b1; W_Addr0 = 5'd3; W_Data0 = 32'h33333333;
        W_En1 = 1'b1; W_Addr1 = 5'd4; W_Data1 = 32'h44444444;
        step();
        idle_inputs();
        R_Addr_A = 5'd3;
        R_Addr_B = 5'd4;
        peek();
        cmp("sep_wr_a", R_Data_A, 32'h33333333);
        cmp("sep_wr_b", R_Data_B, 32'h44444444);
        step();

        // Same-cycle bypass.
        W_En0 = 1'b1; W_Addr0 = 5'd9; W_Data0 = 32'h00000055;
        R_Addr_A = 5'd9;
        peek();
        cmp("bypass", R_Data_A, 32'h00000055);
        step();
        idle_inputs();

        // Scoreboard.
        Set_Pend = 1'b1; P_Addr = 5'd5;
        step();
        idle_inputs();
        R_Addr_A = 5'd5;
        peek();
        cmp1("pend_set", Pend_A, 1'b1);
        step();
        W_En0 = 1'b1; W_Addr0 = 5'd5; W_Data0 = 32'd1; R_Addr_A = 5'd5;
        step();
        idle_inputs();
        R_Addr_A = 5'd5;
        peek();
        cmp1("pend_clr", Pend_A, 1'b0);
        step();
        Set_Pend = 1'b1; P_Addr = 5'd5;
        W_En1 = 1'b1; W_Addr1 = 5'd5; W_Data1 = 32'd2;
        step();
        idle_inputs();
        R_Addr_A = 5'd5;
        peek();
        cmp1("pend_set_wins", Pend_A, 1'b1);
        step();
        Set_Pend = 1'b1; P_Addr = 5'd0;
        step();
        idle_inputs();
        R_Addr_A = 5'd0;
        peek();
        cmp1("pend_zero", Pend_A, 1'b0);
        step();

        // Bulk clear of a fully populated file.
        for (int i = 0; i < DEPTH / 2; i++) begin
            W_En0 = 1'b1; W_Addr0 = 5'(2 * i);     W_Data0 = 32'h01000000 + 32'(i);
            W_En1 = 1'b1; W_Addr1 = 5'(2 * i + 1); W_Data1 = 32'h02000000 + 32'(i);
            step();
        end
        idle_inputs();
        R_Addr_A = 5'd2;
        peek();
        cmp("fill_rd", R_Data_A, 32'h01000001);
        Clr_Req = 1'b1;
        step();
        Clr_Req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 20) begin
                W_En0 = 1'b1; W_Addr0 = 5'd2; W_Data0 = 32'hFFFFFFFF;
            end else begin
                W_En0 = 1'b0;
            end
            peek();
            if (Busy) busy_cnt++;
            if (Clr_Done) begin
                done_cnt++;
                done_at = k;
            end
            step();
        end
        idle_inputs();
        cmp("busy_len", 32'(busy_cnt), 32'd32);
        cmp("done_at", 32'(done_at), 32'd33);
        cmp("done_cnt", 32'(done_cnt), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            R_Addr_A = 5'(i);
            peek();
            cmp("clr_rd", R_Data_A, 32'd0);
            step();
        end

        // Reset at cycle 10 of a clear.
        W_En0 = 1'b1; W_Addr0 = 5'd20; W_Data0 = 32'h0000ABCD;
        W_En1 = 1'b1; W_Addr1 = 5'd25; W_Data1 = 32'h00001234;
        step();
        idle_inputs();
        Clr_Req = 1'b1;
        step();
        Clr_Req = 1'b0;
        for (int k = 1; k < 10; k++) begin
            step();
        end
        RST = 1'b1;
        R_Addr_A = 5'd20;
        R_Addr_B = 5'd25;
        peek();
        cmp1("mc_busy", Busy, 1'b0);
        cmp1("mc_done", Clr_Done, 1'b0);
        cmp("mc_rd_a", R_Data_A, 32'd0);
        cmp("mc_rd_b", R_Data_B, 32'd0);
        step();
        RST = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            peek();
            if (Clr_Done) done_cnt++;
            step();
        end
        cmp("mc_no_done", 32'(done_cnt), 32'd0);
        W_En0 = 1'b1; W_Addr0 = 5'd6; W_Data0 = 32'h0000CAFE;
        step();
        idle_inputs();
        R_Addr_A = 5'd6;
        peek();
        cmp("post_rst_wr", R_Data_A, 32'h0000CAFE);
        step();

        // More random traffic.
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            step();
        end
        idle_inputs();
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
